ibex_axi4l_bridge: RTL and testbench
====================================

IBEX_AXI4L_BRIDGE -- requirements
Module: ibex_axi4l_bridge

Interface
REQ-001 The block SHALL have parameter PROT, default 3'b000, driven constant on axi.awprot and axi.arprot.
REQ-002 The block SHALL have port clk  input  1  single clock for all logic; axi.aclk SHALL be driven from clk.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low; axi.aresetn SHALL be driven from rst_n.
REQ-004 The block SHALL have port data_req  input  1  Ibex LSU request.
REQ-005 The block SHALL have port data_gnt  output  1  request accepted.
REQ-006 The block SHALL have port data_rvalid  output  1  response valid, single-cycle pulse.
REQ-007 The block SHALL have port data_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port data_be  input  4  byte enables.
REQ-009 The block SHALL have port data_addr  input  32  byte address.
REQ-010 The block SHALL have port data_wdata  input  32  write data.
REQ-011 The block SHALL have port data_rdata  output  32  read data, valid with data_rvalid.
REQ-012 The block SHALL have port data_err  output  1  bus error, valid with data_rvalid.
REQ-013 The block SHALL have port axi  axi4l_if master  --  AXI4-Lite master toward slaves (e.g. axi4l_timer).

Function
REQ-014 The block SHALL allow at most one outstanding transaction; FSM states IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, plus RSP when AXI4L_BRIDGE_RSP_REG_EN is defined.
REQ-015 data_gnt SHALL equal data_req in IDLE (combinational) and 0 in every other state.
REQ-016 On data_req & data_gnt, addr/wdata/be SHALL be captured; next state is WR_REQ if data_we, else RD_REQ.
REQ-017 WR_REQ: awvalid and wvalid SHALL both rise the cycle after grant; awaddr = captured addr, wdata = captured wdata, wstrb = captured be.
REQ-018 Each of awvalid/wvalid SHALL drop independently after its own handshake; address and data are held stable while valid and not ready.
REQ-019 AW and W handshakes SHALL be accepted in either order or the same cycle; WR_REQ -> WR_RSP once both are complete.
REQ-020 WR_RSP: bready = 1; on bvalid, write response completes with data_err = (bresp != OKAY) and data_rdata = 0.
REQ-021 RD_REQ: arvalid = 1, araddr = captured addr, held stable until arready; then -> RD_RSP.
REQ-022 RD_RSP: rready = 1; on rvalid, data_rdata = axi.rdata, data_err = (rresp != OKAY).
REQ-023 bready SHALL be 0 outside WR_RSP and rready SHALL be 0 outside RD_RSP.
REQ-024 SLVERR and DECERR SHALL both map to data_err = 1; OKAY and EXOKAY SHALL both map to data_err = 0.
REQ-025 data_rvalid SHALL be exactly one cycle per granted request and never in the grant cycle.
REQ-026 data_req held high across completion SHALL be granted in the first IDLE cycle after completion.
REQ-027 Minimum read latency (arready in first cycle, rvalid the next) SHALL be grant T0, arvalid T1, data_rvalid T2.

Reset
REQ-028 While rst_n = 0 at a clk edge, the FSM SHALL enter IDLE and awvalid, wvalid, arvalid, bready, rready, data_rvalid, data_err SHALL be 0; data_rdata SHALL be 0.
REQ-029 A reset mid-transaction SHALL abandon it with no data_rvalid; all AXI valids SHALL be 0 from the cycle after the reset edge.
REQ-030 No AXI valid SHALL assert in the first cycle after rst_n rises.

Configuration
REQ-031 With AXI4L_BRIDGE_RSP_REG_EN defined, data_rvalid/data_rdata/data_err SHALL be registered: data_rvalid is one cycle after the B/R handshake, the FSM passes through RSP and returns to IDLE after data_rvalid, and minimum read latency is T3.
REQ-032 Without AXI4L_BRIDGE_RSP_REG_EN, data_rvalid SHALL be combinational from the B/R handshake, the FSM returns to IDLE on the handshake cycle, and there is no RSP state.

Verification
REQ-033 Read addr 0x0000_0000, slave arready and rvalid immediate with rdata 0x12345678/OKAY -> data_rvalid at T2 (T3 with REG_EN) with rdata 0x12345678, err 0.
REQ-034 Write addr 0x4, wdata 0xDEADBEEF, be 4'b0011, wready 3 cycles before awready -> awaddr 0x4, wstrb 4'b0011, one data_rvalid after bvalid, err 0.
REQ-035 Read with rresp SLVERR -> data_err 1; write with bresp DECERR -> data_err 1.
REQ-036 data_req held high for 5 back-to-back reads -> exactly 5 gnt and 5 rvalid pulses, no gnt while busy.
REQ-037 Slave stalls arready 4 cycles -> araddr/arvalid stable throughout.
REQ-038 rst_n low during WR_RSP -> no data_rvalid, all valids 0 next cycle, next request proceeds normally.

Source files
------------

// File: rtl/ibex_axi4l_bridge_if.sv
// axi4l_if: AXI4-Lite bus bundle; the master side also drives the bus clock and reset.
interface axi4l_if;
  logic        aclk;
  logic        aresetn;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master (
    output aclk, aresetn, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  aclk, aresetn, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ibex_axi4l_bridge.sv
// ibex_axi4l_bridge: Ibex LSU data port to AXI4-Lite master, one transaction outstanding.
// Define AXI4L_BRIDGE_RSP_REG_EN to register the LSU response through an extra RSP state.
module ibex_axi4l_bridge #(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  axi4l_if.master     axi
);
`ifdef AXI4L_BRIDGE_RSP_REG_EN
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP} state_t;
  localparam state_t DONE = RSP;
`else
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP} state_t;
  localparam state_t DONE = IDLE;
`endif
  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rsp_data;
  logic [3:0]  be_q;
  logic        aw_done, w_done;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs, rsp_err;
  assign awvalid  = state_q == WR_REQ && !aw_done;
  assign wvalid   = state_q == WR_REQ && !w_done;
  assign arvalid  = state_q == RD_REQ;
  assign bready   = state_q == WR_RSP;
  assign rready   = state_q == RD_RSP;
  assign aw_hs    = awvalid && axi.awready;
  assign w_hs     = wvalid && axi.wready;
  assign ar_hs    = arvalid && axi.arready;
  assign b_hs     = bready && axi.bvalid;
  assign r_hs     = rready && axi.rvalid;
  assign rsp_hs   = b_hs || r_hs;
  // SLVERR/DECERR have the top resp bit set; OKAY/EXOKAY do not
  assign rsp_err  = b_hs ? axi.bresp >= 2'b10 : axi.rresp >= 2'b10;
  assign rsp_data = r_hs ? axi.rdata : '0;
  assign data_gnt = rst_n && state_q == IDLE && data_req;
  assign axi.aclk    = clk;
  assign axi.aresetn = rst_n;
  assign axi.awvalid = awvalid;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = PROT;
  assign axi.wvalid  = wvalid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.bready  = bready;
  assign axi.arvalid = arvalid;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = PROT;
  assign axi.rready  = rready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = data_req ? (data_we ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_d = (aw_done || aw_hs) && (w_done || w_hs) ? WR_RSP : WR_REQ;
      WR_RSP:  state_d = b_hs ? DONE : WR_RSP;
      RD_REQ:  state_d = ar_hs ? RD_RSP : RD_REQ;
      RD_RSP:  state_d = r_hs ? DONE : RD_RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (data_gnt) begin
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
        be_q    <= data_be;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end
    end
  end
`ifdef AXI4L_BRIDGE_RSP_REG_EN
  logic [31:0] rdata_q;
  logic        err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rsp_data;
      err_q   <= rsp_hs && rsp_err;
    end
  end
  assign data_rvalid = rst_n && state_q == RSP;
  assign data_rdata  = rdata_q;
  assign data_err    = err_q;
`else
  assign data_rvalid = rst_n && rsp_hs;
  assign data_rdata  = data_rvalid ? rsp_data : '0;
  assign data_err    = data_rvalid && rsp_err;
`endif
endmodule

// File: tb/tb_ibex_axi4l_bridge.sv
// tb_ibex_axi4l_bridge: directed LSU transactions against a configurable AXI4-Lite slave,
// with expected responses queued at grant and checked by an independent monitor.
module tb_ibex_axi4l_bridge;
`ifdef AXI4L_BRIDGE_RSP_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  axi4l_if axi_bus ();
  ibex_axi4l_bridge dut (
    .clk(clk), .rst_n(rst_n), .data_req(data_req), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_err(data_err), .axi(axi_bus)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, rv_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave model: decisions made on the falling edge, handshakes land on the next rising edge
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          r_pend, b_pend, aw_got, w_got, ar_fire, r_fire, aw_fire, w_fire, b_fire;
  bit          p_ar, p_aw, p_w;
  logic [31:0] p_araddr, p_awaddr, p_wdata, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.awready = 1'b0;
      axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
      axi_bus.rdata = '0; axi_bus.rresp = '0; axi_bus.bresp = '0;
      {r_pend, b_pend, aw_got, w_got, ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;
      {p_ar, p_aw, p_w} = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (p_ar) begin
        chk("arvalid_stable", axi_bus.arvalid, 1);
        chk("araddr_stable", axi_bus.araddr, p_araddr);
      end
      if (p_aw) begin
        chk("awvalid_stable", axi_bus.awvalid, 1);
        chk("awaddr_stable", axi_bus.awaddr, p_awaddr);
      end
      if (p_w) begin
        chk("wvalid_stable", axi_bus.wvalid, 1);
        chk("wdata_stable", axi_bus.wdata, p_wdata);
      end
      if (ar_fire) begin r_pend = 1; r_cnt = 0; end
      if (r_fire) axi_bus.rvalid = 1'b0;
      if (aw_fire) aw_got = 1;
      if (w_fire) w_got = 1;
      if (b_fire) axi_bus.bvalid = 1'b0;
      axi_bus.arready = axi_bus.arvalid && ar_cnt >= ar_dly;
      ar_cnt = axi_bus.arvalid ? ar_cnt + 1 : 0;
      axi_bus.awready = axi_bus.awvalid && aw_cnt >= aw_dly;
      aw_cnt = axi_bus.awvalid ? aw_cnt + 1 : 0;
      axi_bus.wready = axi_bus.wvalid && w_cnt >= w_dly;
      w_cnt = axi_bus.wvalid ? w_cnt + 1 : 0;
      if (r_pend && !axi_bus.rvalid) begin
        if (r_cnt >= r_dly) begin
          axi_bus.rvalid = 1'b1; axi_bus.rdata = s_rdata; axi_bus.rresp = s_rresp; r_pend = 0;
        end
        r_cnt++;
      end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      if (b_pend) begin
        if (b_cnt >= b_dly) begin axi_bus.bvalid = 1'b1; axi_bus.bresp = s_bresp; b_pend = 0; end
        b_cnt++;
      end
      ar_fire = axi_bus.arvalid && axi_bus.arready;
      r_fire  = axi_bus.rvalid && axi_bus.rready;
      aw_fire = axi_bus.awvalid && axi_bus.awready;
      w_fire  = axi_bus.wvalid && axi_bus.wready;
      b_fire  = axi_bus.bvalid && axi_bus.bready;
      if (aw_fire) cap_awaddr = axi_bus.awaddr;
      if (w_fire) begin cap_wdata = axi_bus.wdata; cap_wstrb = axi_bus.wstrb; end
      p_ar = axi_bus.arvalid && !axi_bus.arready; p_araddr = axi_bus.araddr;
      p_aw = axi_bus.awvalid && !axi_bus.awready; p_awaddr = axi_bus.awaddr;
      p_w  = axi_bus.wvalid && !axi_bus.wready;   p_wdata  = axi_bus.wdata;
    end
  end

  typedef struct {logic [31:0] rdata; logic err; int lat; int gcyc;} exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (data_rvalid) begin
      rv_cnt++;
      chk("rvalid_in_gnt_cycle", data_gnt, 0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: got data_rvalid=1 with rdata 0x%08h, expected no response", data_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", data_rdata, e.rdata);
        chk("err", data_err, e.err);
        if (e.lat >= 0) chk("latency", cyc - e.gcyc, e.lat);
      end
    end
  end

  task automatic wait_gnt(output bit ok);
    int n = 0;
    ok = 0;
    while (n < 50) begin
      #1;
      if (data_gnt) begin ok = 1; break; end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no data_gnt in 50 cycles, expected a grant");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); #2; n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input bit ee, input int lat);
    bit ok;
    @(negedge clk);
    data_req = 1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
    wait_gnt(ok);
    if (ok) exp_q.push_back('{er, ee, lat, cyc});
    @(posedge clk); #1;
    data_req = 0;
    if (ok && we) begin
      chk("awvalid_t1", axi_bus.awvalid, 1);
      chk("wvalid_t1", axi_bus.wvalid, 1);
    end else if (ok) chk("arvalid_t1", axi_bus.arvalid, 1);
    drain();
  endtask

  initial begin
    bit ok;
    int g, prev, rv0, n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid", data_rvalid, 0);
    chk("rst_err", data_err, 0);
    chk("rst_rdata", data_rdata, 0);
    chk("rst_valids", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}, 0);
    chk("rst_readies", {axi_bus.bready, axi_bus.rready}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_valids", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}, 0);

    s_rdata = 32'h12345678; s_rresp = 2'b00;
    issue(0, 32'h0, 32'h0, 4'hF, 32'h12345678, 0, LAT);

    aw_dly = 3; w_dly = 0; b_dly = 0; s_bresp = 2'b00;
    issue(1, 32'h4, 32'hDEADBEEF, 4'b0011, 32'h0, 0, -1);
    chk("awaddr", cap_awaddr, 32'h4);
    chk("wstrb", cap_wstrb, 4'b0011);
    chk("wdata", cap_wdata, 32'hDEADBEEF);

    aw_dly = 0; ar_dly = 1; r_dly = 2; s_rdata = 32'hCAFEF00D; s_rresp = 2'b10;
    issue(0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1, -1);

    w_dly = 2; b_dly = 1; s_bresp = 2'b11;
    issue(1, 32'h24, 32'h11223344, 4'b1100, 32'h0, 1, -1);
    chk("wstrb_decerr", cap_wstrb, 4'b1100);

    ar_dly = 0; r_dly = 0; s_rdata = 32'h55AA55AA; s_rresp = 2'b01;
    issue(0, 32'h28, 32'h0, 4'hF, 32'h55AA55AA, 0, LAT);

    w_dly = 0; b_dly = 0; s_bresp = 2'b01;
    issue(1, 32'h2C, 32'hA5A5A5A5, 4'hF, 32'h0, 0, -1);
    chk("awaddr_same_cycle", cap_awaddr, 32'h2C);

    ar_dly = 4; s_rdata = 32'h0F0F0F0F; s_rresp = 2'b00;
    issue(0, 32'h1000, 32'h0, 4'hF, 32'h0F0F0F0F, 0, LAT + 4);

    ar_dly = 0; s_rdata = 32'h0BADC0DE; g = 0; prev = 0; rv0 = rv_cnt;
    @(negedge clk);
    data_req = 1; data_we = 0; data_addr = 32'h100;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(ok);
      if (!ok) break;
      exp_q.push_back('{32'h0BADC0DE, 1'b0, -1, cyc});
      if (i > 0) chk("b2b_gnt_gap", cyc - prev, LAT + 1);
      prev = cyc; g++;
      @(posedge clk); #1;
      if (i == 4) data_req = 0; else data_addr = data_addr + 4;
      @(negedge clk);
    end
    data_req = 0;
    drain();
    chk("b2b_gnt_count", g, 5);
    chk("b2b_rvalid_count", rv_cnt - rv0, 5);

    b_dly = 6; s_bresp = 2'b00; rv0 = rv_cnt;
    @(negedge clk);
    data_req = 1; data_we = 1; data_addr = 32'h8; data_wdata = 32'h1; data_be = 4'hF;
    wait_gnt(ok);
    if (ok) exp_q.push_back('{32'h0, 1'b0, -1, cyc});
    @(posedge clk); #1;
    data_req = 0;
    n = 0;
    while (!axi_bus.bready && n < 20) begin @(negedge clk); #1; n++; end
    chk("reached_wr_rsp", axi_bus.bready, 1);
    @(negedge clk);
    rst_n = 0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_valids", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}, 0);
    chk("midrst_readies", {axi_bus.bready, axi_bus.rready}, 0);
    chk("midrst_rvalid", data_rvalid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    b_dly = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_rvalid", rv_cnt - rv0, 0);
    s_rdata = 32'h600DF00D; s_rresp = 2'b00;
    issue(0, 32'h40, 32'h0, 4'hF, 32'h600DF00D, 0, LAT);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion by 200000, expected finish");
    $fatal(1, "timeout");
  end
endmodule
